ahb_data_master: RTL and testbench

//  Bridges the core's data-memory port to an AHB-Lite master interface. Sits between
//  the core's load/store request path and the AHB interconnect that leads to the AHB-APB bridge.

---
 rtl/ahb_data_master.sv | 153 +++++++++++++++
 tb/tb_ahb_data_master.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_data_master.sv
// AHB-Lite master for the core data port: A/D two-entry pipeline, single NONSEQ transfers only.
// Load done 3 cycles after grant; stalls on HREADY low; no grant while A is blocked, during error hold, or misaligned with a busy pipe.
module ahb_data_master #(
  parameter bit         CHECK_ALIGN = 1'b1,
  parameter logic [3:0] HPROT_VAL   = 4'b0011
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        core_req_in,
  input  logic        core_we_in,
  input  logic [1:0]  core_size_in,
  input  logic [31:0] core_addr_in,
  input  logic [31:0] core_wdata_in,
  output logic        core_gnt_out,
  output logic        core_done_out,
  output logic        core_err_out,
  output logic [31:0] core_rdata_out,
  output logic [31:0] haddr_out,
  output logic [1:0]  htrans_out,
  output logic        hwrite_out,
  output logic [2:0]  hsize_out,
  output logic [2:0]  hburst_out,
  output logic [3:0]  hprot_out,
  output logic [31:0] hwdata_out,
  input  logic [31:0] hrdata_in,
  input  logic        hready_in,
  input  logic        hresp_in
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  logic        a_valid_q, a_valid_d;
  logic [31:0] a_addr_q, a_addr_d;
  logic        a_we_q, a_we_d;
  logic [1:0]  a_size_q, a_size_d;
  logic [31:0] a_wdata_q, a_wdata_d;
  logic        d_valid_q, d_valid_d;
  logic        d_we_q, d_we_d;
  logic [31:0] hwdata_q, hwdata_d;
  logic        hold_q, hold_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic misalign;
  logic gnt;
  logic load_a;
  logic adv;
  logic d_cpl;

  always_comb begin
    misalign = 1'b0;
    if (CHECK_ALIGN) begin
      misalign = (core_size_in == 2'b01 && core_addr_in[0])
              || (core_size_in == 2'b10 && core_addr_in[1:0] != 2'b00)
              || (core_size_in == 2'b11);
    end
    // A misaligned request is answered locally, so it must wait until nothing older is in flight.
    gnt    = core_req_in && !hold_q && (!a_valid_q || hready_in)
             && (!misalign || (!a_valid_q && !d_valid_q));
    load_a = gnt && !misalign;
    adv    = hready_in && a_valid_q && !hold_q;
    d_cpl  = hready_in && d_valid_q;
  end

  always_comb begin
    a_valid_d = a_valid_q;
    a_addr_d  = a_addr_q;
    a_we_d    = a_we_q;
    a_size_d  = a_size_q;
    a_wdata_d = a_wdata_q;
    d_valid_d = d_valid_q;
    d_we_d    = d_we_q;
    hwdata_d  = hwdata_q;
    hold_d    = hold_q;
    rdata_d   = rdata_q;

    if (load_a) begin
      a_valid_d = 1'b1;
      a_addr_d  = core_addr_in;
      a_we_d    = core_we_in;
      a_size_d  = core_size_in;
      a_wdata_d = core_wdata_in;
    end else if (adv) begin
      a_valid_d = 1'b0;
    end

    if (hready_in) begin
      d_valid_d = adv;
      if (adv) begin
        d_we_d   = a_we_q;
        hwdata_d = a_wdata_q;
      end
    end

    // First ERROR cycle suppresses the queued address phase until the response finishes.
    if (hready_in) begin
      hold_d = 1'b0;
    end else if (d_valid_q && hresp_in) begin
      hold_d = 1'b1;
    end

    done_d = d_cpl || (gnt && misalign);
    err_d  = d_cpl ? hresp_in : (gnt && misalign);
    if (d_cpl && !d_we_q) begin
      rdata_d = hrdata_in;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      a_valid_q <= 1'b0;
      a_addr_q  <= '0;
      a_we_q    <= 1'b0;
      a_size_q  <= '0;
      a_wdata_q <= '0;
      d_valid_q <= 1'b0;
      d_we_q    <= 1'b0;
      hwdata_q  <= '0;
      hold_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      a_valid_q <= a_valid_d;
      a_addr_q  <= a_addr_d;
      a_we_q    <= a_we_d;
      a_size_q  <= a_size_d;
      a_wdata_q <= a_wdata_d;
      d_valid_q <= d_valid_d;
      d_we_q    <= d_we_d;
      hwdata_q  <= hwdata_d;
      hold_q    <= hold_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  assign core_gnt_out   = gnt;
  assign core_done_out  = done_q;
  assign core_err_out   = err_q;
  assign core_rdata_out = rdata_q;
  assign haddr_out      = a_addr_q;
  assign htrans_out     = (a_valid_q && !hold_q) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign hwrite_out     = a_we_q;
  assign hsize_out      = {1'b0, a_size_q};
  assign hburst_out     = 3'b000;
  assign hprot_out      = HPROT_VAL;
  assign hwdata_out     = hwdata_q;

endmodule

// File: tb/tb_ahb_data_master.sv
// Directed bench for ahb_data_master: bus-side checks inline, completions checked by a scoreboard monitor.
module tb_ahb_data_master;

  logic        clk_in;
  logic        rst_in;
  logic        core_req_in;
  logic        core_we_in;
  logic [1:0]  core_size_in;
  logic [31:0] core_addr_in;
  logic [31:0] core_wdata_in;
  logic        core_gnt_out;
  logic        core_done_out;
  logic        core_err_out;
  logic [31:0] core_rdata_out;
  logic [31:0] haddr_out;
  logic [1:0]  htrans_out;
  logic        hwrite_out;
  logic [2:0]  hsize_out;
  logic [2:0]  hburst_out;
  logic [3:0]  hprot_out;
  logic [31:0] hwdata_out;
  logic [31:0] hrdata_in;
  logic        hready_in;
  logic        hresp_in;

  ahb_data_master dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .core_req_in(core_req_in), .core_we_in(core_we_in), .core_size_in(core_size_in),
    .core_addr_in(core_addr_in), .core_wdata_in(core_wdata_in),
    .core_gnt_out(core_gnt_out), .core_done_out(core_done_out), .core_err_out(core_err_out),
    .core_rdata_out(core_rdata_out),
    .haddr_out(haddr_out), .htrans_out(htrans_out), .hwrite_out(hwrite_out),
    .hsize_out(hsize_out), .hburst_out(hburst_out), .hprot_out(hprot_out),
    .hwdata_out(hwdata_out), .hrdata_in(hrdata_in), .hready_in(hready_in), .hresp_in(hresp_in)
  );

  typedef struct {
    logic        err;
    logic        chk_rd;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic err, input logic chk_rd, input logic [31:0] rd);
    exp_t e;
    e.err = err;
    e.chk_rd = chk_rd;
    e.rdata = rd;
    sb_q.push_back(e);
  endtask

  task automatic idle_in();
    core_req_in   = 1'b0;
    core_we_in    = 1'b0;
    core_size_in  = 2'b00;
    core_addr_in  = '0;
    core_wdata_in = '0;
    hready_in     = 1'b1;
    hresp_in      = 1'b0;
    hrdata_in     = '0;
  endtask

  task automatic req(input logic we, input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] wd);
    core_req_in   = 1'b1;
    core_we_in    = we;
    core_size_in  = sz;
    core_addr_in  = addr;
    core_wdata_in = wd;
  endtask

  task automatic neg();
    @(negedge clk_in);
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Every completion pulse must match the oldest outstanding expectation.
  always @(negedge clk_in) begin
    if (core_done_out) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_done: got done=1 with nothing outstanding, required done=0 (t=%0t)", $time);
      end else begin
        mon_e = sb_q.pop_front();
        chk("done_err", 32'(core_err_out), 32'(mon_e.err));
        if (mon_e.chk_rd) chk("done_rdata", core_rdata_out, mon_e.rdata);
      end
    end
  end

  initial begin
    rst_in = 1'b0;
    idle_in();
    neg();
    chk("rst_htrans", 32'(htrans_out), 'h0);
    chk("rst_haddr", haddr_out, 'h0);
    chk("rst_hwrite", 32'(hwrite_out), 'h0);
    chk("rst_hsize", 32'(hsize_out), 'h0);
    chk("rst_hwdata", hwdata_out, 'h0);
    chk("rst_done", 32'(core_done_out), 'h0);
    chk("rst_err", 32'(core_err_out), 'h0);
    chk("rst_rdata", core_rdata_out, 'h0);
    chk("hburst", 32'(hburst_out), 'h0);
    chk("hprot", 32'(hprot_out), 'h3);
    step();
    rst_in = 1'b1;
    step();

    // 1: single zero-wait word load
    req(1'b0, 2'b10, 32'h40, 32'h0);
    neg(); chk("t1_gnt", 32'(core_gnt_out), 'h1); chk("t1_idle", 32'(htrans_out), 'h0);
    push(1'b0, 1'b1, 32'hCAFE0040); step();
    core_req_in = 1'b0;
    neg(); chk("t1_htrans", 32'(htrans_out), 'h2); chk("t1_haddr", haddr_out, 'h40);
    chk("t1_hsize", 32'(hsize_out), 'h2); chk("t1_hwrite", 32'(hwrite_out), 'h0); step();
    hrdata_in = 32'hCAFE0040;
    neg(); chk("t1_no_early_done", 32'(core_done_out), 'h0); chk("t1_dphase_idle", 32'(htrans_out), 'h0); step();
    hrdata_in = 32'h0;
    neg(); chk("t1_done", 32'(core_done_out), 'h1); step();

    // 2: store then load back-to-back
    req(1'b1, 2'b10, 32'h80, 32'h11112222);
    neg(); chk("t2_gnt_st", 32'(core_gnt_out), 'h1); push(1'b0, 1'b1, 32'hCAFE0040); step();
    req(1'b0, 2'b10, 32'h84, 32'h0);
    neg(); chk("t2_gnt_ld", 32'(core_gnt_out), 'h1); chk("t2_st_addr", haddr_out, 'h80);
    chk("t2_st_write", 32'(hwrite_out), 'h1); push(1'b0, 1'b1, 32'h55556666); step();
    core_req_in = 1'b0;
    neg(); chk("t2_ld_addr", haddr_out, 'h84); chk("t2_ld_htrans", 32'(htrans_out), 'h2);
    chk("t2_ld_write", 32'(hwrite_out), 'h0); chk("t2_hwdata", hwdata_out, 'h11112222); step();
    hrdata_in = 32'h55556666;
    neg(); chk("t2_done_st", 32'(core_done_out), 'h1); step();
    hrdata_in = 32'h0;
    neg(); chk("t2_done_ld", 32'(core_done_out), 'h1); step();
    neg(); chk("t2_quiet", 32'(core_done_out), 'h0); step();

    // 3: load with 3 wait states, next two requests queued behind it
    req(1'b0, 2'b10, 32'hC0, 32'hDEAD00C0);
    neg(); chk("t3_gnt1", 32'(core_gnt_out), 'h1); push(1'b0, 1'b1, 32'h3333AAAA); step();
    req(1'b0, 2'b10, 32'hC4, 32'h0);
    neg(); chk("t3_gnt2", 32'(core_gnt_out), 'h1); chk("t3_addr1", haddr_out, 'hC0);
    push(1'b0, 1'b1, 32'h4444BBBB); step();
    req(1'b0, 2'b10, 32'hC8, 32'h0);
    hready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      neg();
      chk("t3_wait_gnt", 32'(core_gnt_out), 'h0);
      chk("t3_wait_haddr", haddr_out, 'hC4);
      chk("t3_wait_htrans", 32'(htrans_out), 'h2);
      chk("t3_wait_hwdata", hwdata_out, 'hDEAD00C0);
      chk("t3_wait_done", 32'(core_done_out), 'h0);
      step();
    end
    hready_in = 1'b1;
    hrdata_in = 32'h3333AAAA;
    neg(); chk("t3_gnt3", 32'(core_gnt_out), 'h1); push(1'b0, 1'b1, 32'h5555CCCC); step();
    core_req_in = 1'b0;
    hrdata_in = 32'h4444BBBB;
    neg(); chk("t3_done1", 32'(core_done_out), 'h1); chk("t3_addr3", haddr_out, 'hC8); step();
    hrdata_in = 32'h5555CCCC;
    neg(); chk("t3_done2", 32'(core_done_out), 'h1); step();
    hrdata_in = 32'h0;
    neg(); chk("t3_done3", 32'(core_done_out), 'h1); step();
    neg(); chk("t3_quiet", 32'(core_done_out), 'h0); step();

    // 4: ERROR on the first of two pipelined loads
    req(1'b0, 2'b10, 32'h200, 32'h0);
    neg(); chk("t4_gnt1", 32'(core_gnt_out), 'h1); push(1'b1, 1'b1, 32'hEEEE0000); step();
    req(1'b0, 2'b10, 32'h204, 32'h0);
    neg(); chk("t4_gnt2", 32'(core_gnt_out), 'h1); push(1'b0, 1'b1, 32'h7777DDDD); step();
    core_req_in = 1'b0;
    hready_in = 1'b0; hresp_in = 1'b1;
    neg(); chk("t4_err1_htrans", 32'(htrans_out), 'h2); chk("t4_err1_haddr", haddr_out, 'h204); step();
    req(1'b0, 2'b10, 32'h208, 32'h0);
    hready_in = 1'b1; hrdata_in = 32'hEEEE0000;
    neg(); chk("t4_err2_idle", 32'(htrans_out), 'h0); chk("t4_hold_gnt", 32'(core_gnt_out), 'h0); step();
    hresp_in = 1'b0; hrdata_in = 32'h0;
    neg(); chk("t4_err_done", 32'(core_done_out), 'h1); chk("t4_replay", 32'(htrans_out), 'h2);
    chk("t4_replay_addr", haddr_out, 'h204); chk("t4_gnt3", 32'(core_gnt_out), 'h1);
    push(1'b0, 1'b1, 32'h8888EEEE); step();
    core_req_in = 1'b0;
    hrdata_in = 32'h7777DDDD;
    neg(); chk("t4_gap", 32'(core_done_out), 'h0); chk("t4_addr3", haddr_out, 'h208); step();
    hrdata_in = 32'h8888EEEE;
    neg(); chk("t4_done2", 32'(core_done_out), 'h1); step();
    hrdata_in = 32'h0;
    neg(); chk("t4_done3", 32'(core_done_out), 'h1); step();

    // 5: misaligned halfword store, first with empty pipe, then behind a load
    req(1'b1, 2'b01, 32'h101, 32'h0000BEEF);
    neg(); chk("t5_gnt_empty", 32'(core_gnt_out), 'h1); chk("t5_idle0", 32'(htrans_out), 'h0);
    push(1'b1, 1'b0, 32'h0); step();
    core_req_in = 1'b0;
    neg(); chk("t5_done", 32'(core_done_out), 'h1); chk("t5_idle1", 32'(htrans_out), 'h0); step();
    neg(); chk("t5_quiet", 32'(core_done_out), 'h0); chk("t5_idle2", 32'(htrans_out), 'h0); step();
    req(1'b0, 2'b10, 32'h300, 32'h0);
    neg(); chk("t5_gnt_ld", 32'(core_gnt_out), 'h1); push(1'b0, 1'b1, 32'h9999FFFF); step();
    req(1'b1, 2'b01, 32'h101, 32'h0000BEEF);
    neg(); chk("t5_wait_a", 32'(core_gnt_out), 'h0); chk("t5_ld_addr", haddr_out, 'h300); step();
    hrdata_in = 32'h9999FFFF;
    neg(); chk("t5_wait_d", 32'(core_gnt_out), 'h0); chk("t5_no_issue", 32'(htrans_out), 'h0); step();
    hrdata_in = 32'h0;
    neg(); chk("t5_gnt_late", 32'(core_gnt_out), 'h1); chk("t5_ld_done", 32'(core_done_out), 'h1);
    push(1'b1, 1'b0, 32'h0); step();
    core_req_in = 1'b0;
    neg(); chk("t5_mis_done", 32'(core_done_out), 'h1); chk("t5_idle3", 32'(htrans_out), 'h0); step();
    neg(); chk("t5_quiet2", 32'(core_done_out), 'h0); step();

    // 6: reset during a wait-stated data phase
    req(1'b0, 2'b10, 32'h400, 32'h0);
    neg(); chk("t6_gnt", 32'(core_gnt_out), 'h1); step();
    core_req_in = 1'b0;
    neg(); chk("t6_htrans", 32'(htrans_out), 'h2); step();
    hready_in = 1'b0;
    #2;
    rst_in = 1'b0;
    #1;
    chk("t6_rst_htrans", 32'(htrans_out), 'h0);
    chk("t6_rst_haddr", haddr_out, 'h0);
    chk("t6_rst_hwdata", hwdata_out, 'h0);
    chk("t6_rst_rdata", core_rdata_out, 'h0);
    chk("t6_rst_done", 32'(core_done_out), 'h0);
    step();
    step();
    hready_in = 1'b1;
    rst_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      neg();
      chk("t6_no_done", 32'(core_done_out), 'h0);
      chk("t6_idle", 32'(htrans_out), 'h0);
      step();
    end

    chk("sb_drained", 32'(sb_q.size()), 'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
